// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the calculator control slice.
//   * default widths for the accumulator, key register and multiply length
//   * opcode encoding seen on inOp
//   * FSM state encoding used by calc_sequencer
package calc_pkg;

  localparam int ACC_W_DEF      = 16;  // accumulator / display width
  localparam int KEY_W_DEF      = 4;   // keypad digit register width
  localparam int MUL_CYCLES_DEF = 4;   // one multiplier bit per cycle

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // display shows the accumulator
    ST_ENTRY = 2'b01,  // display shows the operand being keyed in
    ST_EXEC  = 2'b10,  // single-cycle ADD/SUB/LOAD
    ST_MUL   = 2'b11   // iterative shift-add multiply
  } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq -- unsigned shift-add multiplier, one multiplier bit per
// clock, LSB first.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : abort, discards any partial product
//   start          : load operands, product cleared, counter cleared
//   multiplicand   : ACC_W-bit operand
//   multiplier     : KEY_W-bit operand
//   done           : high during the cycle whose edge completes the product
//   product        : running product including the current step; valid as
//                    the final product while done is high
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic [ACC_W-1:0]       multiplicand,
  input  logic [KEY_W-1:0]       multiplier,
  output logic                   done,
  output logic [ACC_W+KEY_W-1:0] product
);

  localparam int PROD_W = ACC_W + KEY_W;
  localparam int CNT_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  logic              busy_q,   busy_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ACC_W-1:0]  mcand_q,  mcand_d;
  logic [KEY_W-1:0]  mplier_q, mplier_d;
  logic [PROD_W-1:0] prod_q,   prod_d;

  logic [PROD_W-1:0] addend;
  logic [PROD_W-1:0] prod_sum;
  logic              last_step;

  always_comb begin
    addend    = '0;
    if (mplier_q[cnt_q]) begin
      addend = {{KEY_W{1'b0}}, mcand_q} << cnt_q;
    end
    prod_sum  = prod_q + addend;
    last_step = (cnt_q == CNT_W'(KEY_W - 1));
  end

  // The final step's sum is handed out combinationally so the owner can
  // commit it on the same edge that retires the last multiplier bit.
  assign done    = busy_q && last_step;
  assign product = prod_sum;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (clear) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      prod_d = '0;
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = multiplicand;
      mplier_d = multiplier;
      prod_d   = '0;
    end else if (busy_q) begin
      prod_d = prod_sum;
      cnt_d  = cnt_q + 1'b1;
      if (last_step) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer -- control FSM for the calculator datapath. Owns the key
// register, the accumulator and the sequential multiplier.
//   clk, rst_n  : clock, asynchronous active-low reset
//   inKey       : keypad digit, qualified by inKeyValid
//   inOp        : opcode (ADD/SUB/MUL/LOAD), qualified by inOpValid
//   inClear     : clear request, overrides every other input in any state
//   outReg      : key register (display mux operand input)
//   outAcc      : accumulator (display mux result input)
//   outSelect   : 0 = show key register, 1 = show accumulator
//   outBusy     : operation in progress; strobes are dropped while high
//   outOverflow : sticky carry / borrow / multiply overflow
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF  // must equal KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] inKey,
  input  logic             inKeyValid,
  input  logic [1:0]       inOp,
  input  logic             inOpValid,
  input  logic             inClear,
  output logic [KEY_W-1:0] outReg,
  output logic [ACC_W-1:0] outAcc,
  output logic             outSelect,
  output logic             outBusy,
  output logic             outOverflow
);

  state_e           state_q, state_d;
  op_e              op_q,    op_d;
  logic [KEY_W-1:0] reg_q,   reg_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic             ovf_q,   ovf_d;

  logic                   accepting;
  logic                   mul_start;
  logic [KEY_W-1:0]       mul_multiplier;
  logic                   mul_done;
  logic [ACC_W+KEY_W-1:0] mul_product;
  logic [ACC_W:0]         add_sum;
  logic [ACC_W-1:0]       reg_ext;

  assign reg_ext   = {{(ACC_W-KEY_W){1'b0}}, reg_q};
  assign add_sum   = {1'b0, acc_q} + {1'b0, reg_ext};
  assign accepting = (state_q == ST_IDLE) || (state_q == ST_ENTRY);

  // The multiplier loads on the accepting edge; a key arriving on that
  // same edge must be the multiplier, so bypass the key register.
  assign mul_start      = !inClear && accepting && inOpValid && (op_e'(inOp) == OP_MUL);
  assign mul_multiplier = inKeyValid ? inKey : reg_q;

  calc_mul_seq #(
    .ACC_W (ACC_W),
    .KEY_W (KEY_W)
  ) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (inClear),
    .start        (mul_start),
    .multiplicand (acc_q),
    .multiplier   (mul_multiplier),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    reg_d   = reg_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    if (inClear) begin
      state_d = ST_IDLE;
      reg_d   = '0;
      acc_d   = '0;
      sel_d   = 1'b1;
      busy_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (inKeyValid) begin
            reg_d   = inKey;
            sel_d   = 1'b0;
            state_d = ST_ENTRY;
          end
          if (inOpValid) begin
            op_d    = op_e'(inOp);
            busy_d  = 1'b1;
            state_d = (op_e'(inOp) == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD: begin
              acc_d = add_sum[ACC_W-1:0];
              ovf_d = ovf_q | add_sum[ACC_W];
            end
            OP_SUB: begin
              acc_d = acc_q - reg_ext;
              ovf_d = ovf_q | (reg_ext > acc_q);
            end
            OP_LOAD: acc_d = reg_ext;
            default: acc_d = acc_q;
          endcase
          sel_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        ST_MUL: begin
          if (mul_done) begin
            acc_d   = mul_product[ACC_W-1:0];
            ovf_d   = ovf_q | (|mul_product[ACC_W+KEY_W-1:ACC_W]);
            sel_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      reg_q   <= '0;
      acc_q   <= '0;
      sel_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign outReg      = reg_q;
  assign outAcc      = acc_q;
  assign outSelect   = sel_q;
  assign outBusy     = busy_q;
  assign outOverflow = ovf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer -- directed vectors with hand-computed expectations
// for calc_sequencer. Inputs change on the falling edge, outputs are
// sampled on the falling edge (or 1 time unit after a rising edge).
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  inKey = '0;
  logic        inKeyValid = 1'b0;
  logic [1:0]  inOp = '0;
  logic        inOpValid = 1'b0;
  logic        inClear = 1'b0;
  logic [3:0]  outReg;
  logic [15:0] outAcc;
  logic        outSelect;
  logic        outBusy;
  logic        outOverflow;

  int checks = 0;
  int failures = 0;

  calc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inKey       (inKey),
    .inKeyValid  (inKeyValid),
    .inOp        (inOp),
    .inOpValid   (inOpValid),
    .inClear     (inClear),
    .outReg      (outReg),
    .outAcc      (outAcc),
    .outSelect   (outSelect),
    .outBusy     (outBusy),
    .outOverflow (outOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe: driven on a falling edge, sampled by the next rising
  // edge, released on the following falling edge.
  task automatic apply(input logic kv, input logic [3:0] k, input logic ov,
                       input logic [1:0] o, input logic cl);
    @(negedge clk);
    inKeyValid = kv; inKey = k; inOpValid = ov; inOp = o; inClear = cl;
    @(negedge clk);
    inKeyValid = 1'b0; inOpValid = 1'b0; inClear = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] k);
    apply(1'b1, k, 1'b0, 2'b00, 1'b0);
    $display("key %0d: reg=%0d sel=%0d", k, outReg, outSelect);
  endtask

  task automatic clear_pulse();
    apply(1'b0, 4'd0, 1'b0, 2'b00, 1'b1);
    $display("clear: acc=0x%04h reg=%0d ovf=%0d", outAcc, outReg, outOverflow);
  endtask

  // Issues an op and measures how many sampled cycles outBusy stays high.
  task automatic run_op(input string tag, input logic [1:0] o, input int exp_busy);
    int n;
    apply(1'b0, 4'd0, 1'b1, o, 1'b0);
    n = 0;
    while (outBusy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, n, exp_busy);
    $display("op %0d (%s): acc=0x%04h ovf=%0d busy_cycles=%0d", o, tag, outAcc, outOverflow, n);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (outBusy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_idle"}, outBusy, 1'b0);
  endtask

  logic [3:0] build_key [10] = '{4'd15, 4'd8, 4'd2, 4'd15, 4'd8, 4'd2, 4'd15, 4'd8, 4'd2, 4'd14};
  logic [1:0] build_op  [10] = '{OP_LOAD, OP_MUL, OP_MUL, OP_ADD, OP_MUL, OP_MUL,
                                 OP_ADD, OP_MUL, OP_MUL, OP_ADD};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset values
    repeat (2) @(negedge clk);
    check("rst_reg", outReg, 4'd0);
    check("rst_acc", outAcc, 16'd0);
    check("rst_sel", outSelect, 1'b1);
    check("rst_busy", outBusy, 1'b0);
    check("rst_ovf", outOverflow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- 1: asynchronous reset in the middle of a multiply
    press_key(4'd9);
    run_op("t1_load", OP_LOAD, 1);
    check("t1_acc_pre", outAcc, 16'd9);
    press_key(4'd3);
    apply(1'b0, 4'd0, 1'b1, OP_MUL, 1'b0);
    check("t1_busy_mul", outBusy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_acc", outAcc, 16'd0);
    check("t1_async_reg", outReg, 4'd0);
    check("t1_async_sel", outSelect, 1'b1);
    check("t1_async_busy", outBusy, 1'b0);
    check("t1_async_ovf", outOverflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_post_sel", outSelect, 1'b1);
    check("t1_post_acc", outAcc, 16'd0);
    check("t1_post_busy", outBusy, 1'b0);

    // ---- 2: key 5, ADD, key 3, ADD
    press_key(4'd5);
    check("t2_sel_entry", outSelect, 1'b0);
    check("t2_reg5", outReg, 4'd5);
    run_op("t2_add1", OP_ADD, 1);
    check("t2_acc5", outAcc, 16'd5);
    check("t2_sel_acc", outSelect, 1'b1);
    press_key(4'd3);
    run_op("t2_add2", OP_ADD, 1);
    check("t2_acc8", outAcc, 16'd8);
    check("t2_ovf", outOverflow, 1'b0);

    // ---- 3: LOAD 9, MUL 7, then a MUL with strobes injected while busy
    press_key(4'd9);
    run_op("t3_load", OP_LOAD, 1);
    press_key(4'd7);
    run_op("t3_mul", OP_MUL, 4);
    check("t3_acc63", outAcc, 16'd63);
    apply(1'b0, 4'd0, 1'b1, OP_MUL, 1'b0);
    apply(1'b1, 4'd2, 1'b1, OP_ADD, 1'b0);
    check("t3_busy_reg", outReg, 4'd7);
    check("t3_busy_acc", outAcc, 16'd63);
    wait_idle("t3_mul2");
    check("t3_acc441", outAcc, 16'd441);
    check("t3_reg_kept", outReg, 4'd7);
    $display("mul with ignored strobes: acc=%0d reg=%0d", outAcc, outReg);

    // ---- 4a: build 0xFFFE without overflow, then ADD 3 wraps
    clear_pulse();
    for (int i = 0; i < 10; i++) begin
      press_key(build_key[i]);
      run_op("t4_build", build_op[i], (build_op[i] == OP_MUL) ? 4 : 1);
    end
    check("t4_fffe", outAcc, 16'hFFFE);
    check("t4_fffe_ovf", outOverflow, 1'b0);
    press_key(4'd3);
    run_op("t4_add3", OP_ADD, 1);
    check("t4_wrap_acc", outAcc, 16'h0001);
    check("t4_carry_ovf", outOverflow, 1'b1);
    press_key(4'd1);
    run_op("t4_load1", OP_LOAD, 1);
    check("t4_load_acc", outAcc, 16'd1);
    check("t4_sticky_ovf", outOverflow, 1'b1);

    // ---- 4b: clear, LOAD 2, SUB 5 borrows
    clear_pulse();
    check("t4_clr_ovf", outOverflow, 1'b0);
    check("t4_clr_acc", outAcc, 16'd0);
    press_key(4'd2);
    run_op("t4_load2", OP_LOAD, 1);
    press_key(4'd5);
    run_op("t4_sub5", OP_SUB, 1);
    check("t4_sub_acc", outAcc, 16'hFFFD);
    check("t4_borrow_ovf", outOverflow, 1'b1);

    // ---- 4c: reach 0x4000 by multiplies, then MUL 4 overflows to zero
    clear_pulse();
    press_key(4'd8);
    run_op("t4_load8", OP_LOAD, 1);
    run_op("t4_mul8a", OP_MUL, 4);
    run_op("t4_mul8b", OP_MUL, 4);
    run_op("t4_mul8c", OP_MUL, 4);
    check("t4_1000", outAcc, 16'h1000);
    press_key(4'd4);
    run_op("t4_mul4a", OP_MUL, 4);
    check("t4_4000", outAcc, 16'h4000);
    check("t4_4000_ovf", outOverflow, 1'b0);
    run_op("t4_mul4b", OP_MUL, 4);
    check("t4_mul_wrap", outAcc, 16'h0000);
    check("t4_mul_ovf", outOverflow, 1'b1);
    press_key(4'd1);
    run_op("t4_load1b", OP_LOAD, 1);
    check("t4_mul_sticky", outOverflow, 1'b1);

    // ---- 5: key and ADD on the same edge
    clear_pulse();
    press_key(4'd10);
    run_op("t5_load10", OP_LOAD, 1);
    @(negedge clk);
    inKeyValid = 1'b1; inKey = 4'd6; inOpValid = 1'b1; inOp = OP_ADD;
    @(posedge clk);
    #1;
    check("t5_reg6", outReg, 4'd6);
    check("t5_acc_hold", outAcc, 16'd10);
    check("t5_busy", outBusy, 1'b1);
    @(negedge clk);
    inKeyValid = 1'b0; inOpValid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_acc16", outAcc, 16'd16);
    check("t5_sel", outSelect, 1'b1);
    $display("simultaneous key+add: reg=%0d acc=%0d", outReg, outAcc);
    @(negedge clk);

    // ---- 6: clear together with a key on MUL cycle 3
    press_key(4'd15);
    run_op("t6_sub15a", OP_SUB, 1);
    check("t6_acc1", outAcc, 16'd1);
    run_op("t6_sub15b", OP_SUB, 1);
    check("t6_accfff2", outAcc, 16'hFFF2);
    check("t6_ovf_set", outOverflow, 1'b1);
    press_key(4'd5);
    apply(1'b0, 4'd0, 1'b1, OP_MUL, 1'b0);
    @(negedge clk);
    @(negedge clk);
    inClear = 1'b1; inKeyValid = 1'b1; inKey = 4'd9;
    @(negedge clk);
    inClear = 1'b0; inKeyValid = 1'b0;
    check("t6_acc", outAcc, 16'd0);
    check("t6_reg", outReg, 4'd0);
    check("t6_ovf", outOverflow, 1'b0);
    check("t6_sel", outSelect, 1'b1);
    check("t6_busy", outBusy, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_acc_later", outAcc, 16'd0);
    check("t6_sel_later", outSelect, 1'b1);
    $display("clear during mul: acc=%0d reg=%0d ovf=%0d", outAcc, outReg, outOverflow);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM for the calculator datapath.
- Captures keypad digits into the 4-bit input register and executes operations against the 16-bit accumulator register.
- Drives the display-mux select so the display shows the operand being entered, then the result.
- Sits between the keypad/op-button front end and the display mux. Owns both registers and the sequential multiplier.

Parameters:
- ACC_W, 16, accumulator/display width
- KEY_W, 4, input register width
- MUL_CYCLES, 4, multiply iterations; must equal KEY_W

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inKey  in  4  keypad digit value
- inKeyValid  in  1  one-cycle strobe, inKey is valid
- inOp  in  2  operation code: 00 ADD, 01 SUB, 10 MUL, 11 LOAD
- inOpValid  in  1  one-cycle strobe, execute inOp
- inClear  in  1  synchronous clear request
- outReg  out  4  input register, to display mux inReg
- outAcc  out  16  accumulator register, to display mux inAccReg
- outSelect  out  1  display select: 0 shows input register, 1 shows accumulator
- outBusy  out  1  operation in progress; strobes are ignored while high
- outOverflow  out  1  sticky arithmetic overflow/borrow flag

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: outReg=0, outAcc=0, outSelect=1, outBusy=0, outOverflow=0, state IDLE, multiply counter=0.
- States:
  - IDLE: showing the accumulator.
  - ENTRY: showing the operand.
  - EXEC: single-cycle op.
  - MUL: iterative multiply.
- Priority: inClear > inKeyValid/inOpValid. When inClear is sampled high, in any state including mid-MUL:
  - outReg=0, outAcc=0, outOverflow=0, outSelect=1
  - state returns to IDLE
  - any partial product is discarded.
- IDLE/ENTRY, inKeyValid:
  - outReg<=inKey, outSelect<=0, state ENTRY.
  - In ENTRY, each new key overwrites outReg. There is no digit accumulation.
- IDLE/ENTRY, inOpValid: latch inOp, outBusy<=1, then:
  - state EXEC for ADD/SUB/LOAD
  - state MUL for MUL, with counter cleared.
- inKeyValid and inOpValid in the same cycle: the key is latched at the same edge, and the operation uses the new outReg value.
- EXEC lasts exactly 1 cycle. Let N be the edge that accepts the op. At edge N+1:
  - ADD: outAcc<=outAcc+outReg.
  - SUB: outAcc<=outAcc-outReg.
  - LOAD: outAcc<=zero-extended outReg.
  - Then outSelect<=1, outBusy<=0, state IDLE.
- MUL: unsigned shift-add of outAcc by outReg, one multiplier bit per cycle, LSB first, into a 20-bit product.
  - State MUL is held for MUL_CYCLES cycles.
  - At edge N+4: outAcc<=product[15:0], outSelect<=1, outBusy<=0, state IDLE.
- Width/overflow: all arithmetic is unsigned, 16-bit, wrap-around. outOverflow is set (sticky) by any of:
  - ADD carry-out
  - SUB borrow (outReg > outAcc)
  - MUL with product[19:16] != 0
- LOAD never sets outOverflow. Only reset or inClear clears it.
- Strobes in EXEC/MUL (outBusy=1): ignored and not queued. inClear is still honoured.
- After an op, outReg keeps its value. A new op without a new key reuses it, e.g. repeated ADD of the same digit.
- There are no illegal opcodes: all 2-bit codes are defined.

Decomposition:
- Shared package calc_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_LOAD
  - state encoding ST_IDLE/ST_ENTRY/ST_EXEC/ST_MUL
  - ACC_W/KEY_W defaults.
- One sub-module: calc_mul_seq.
  - Shift-add multiplier with start, multiplicand[15:0], multiplier[3:0], 2-bit counter, done pulse, product[19:0].
  - Its start/done handshake is driven by the MUL state.
- The FSM, registers and ADD/SUB/LOAD stay in calc_sequencer.

Test Plan:
1. Reset mid-operation: start MUL, assert rst_n=0 during cycle 2 -> all outputs return to reset values immediately (asynchronous). After release, outSelect=1 and outAcc=0.
2. Key 5, then ADD, then key 3, then ADD -> after key 5: outSelect=0, outReg=5. One cycle after the first ADD: outAcc=5, outSelect=1. After the second: outAcc=8, outBusy high for exactly one cycle each time, outOverflow=0.
3. LOAD 9 then MUL with key 7 -> outBusy high for 4 cycles, then outAcc=63. Strobes injected during busy leave outReg and outAcc unchanged.
4. Wrap/overflow cases, with outOverflow staying sticky through a later LOAD 1:
   - outAcc=0xFFFE, ADD 3 -> outAcc=0x0001, outOverflow=1.
   - After clear, LOAD 2 then SUB 5 -> outAcc=0xFFFD, outOverflow=1.
   - outAcc=0x4000, MUL 4 -> outAcc=0x0000, outOverflow=1.
5. Simultaneous key=6 and op=ADD with outAcc=10 -> outReg=6 at the same edge, outAcc=16 one edge later.
6. inClear asserted on MUL cycle 3 together with inKeyValid -> outAcc=0, outReg=0, outOverflow=0, state IDLE, outSelect=1. The key is ignored.
